// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32I multi-cycle controller.
// ALU codes, opcode values, FSM states and datapath select encodings.
package rv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_SLT = 4'b0100,
    ALU_XOR = 4'b0101
  } alu_op_t;

  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_R,
    CLS_I,
    CLS_BR
  } alu_cls_t;

  localparam logic [6:0] OPC_LW     = 7'b0000011;
  localparam logic [6:0] OPC_SW     = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } ctrl_state_t;

  typedef enum logic [1:0] {
    SRCA_PC,
    SRCA_OLDPC,
    SRCA_RS1
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2,
    SRCB_IMM,
    SRCB_FOUR
  } src_b_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_t;

  typedef enum logic [1:0] {
    RES_ALUOUT,
    RES_MEM,
    RES_ALU
  } res_t;

  // Branch resolution from the SUB flags.
  function automatic logic br_taken(
    input logic [2:0] f3,
    input logic       z,
    input logic       n,
    input logic       c,
    input logic       v
  );
    logic t;
    t = 1'b0;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = !z;
      3'b100:  t = n ^ v;
      3'b101:  t = !(n ^ v);
      3'b110:  t = c;
      3'b111:  t = !c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rv_alu_decoder.sv
// ALU control decoder: op class + funct fields -> ALU code and legality.
// Shifts, SLTU and reserved branch functs are reported as illegal.
module rv_alu_decoder
  import rv_pkg::*;
(
  input  logic [1:0] cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_control,
  output logic       legal
);

  logic is_r;
  assign is_r = (cls == CLS_R);

  // Decode the ALU code for each instruction class.
  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    unique case (1'b1)
      (cls == CLS_BR): begin
        alu_control = ALU_SUB;
        legal       = (funct3[2:1] != 2'b01);
      end
      (cls == CLS_R),
      (cls == CLS_I): begin
        case (funct3)
          3'b000: alu_control = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b111: alu_control = ALU_AND;
          3'b110: alu_control = ALU_OR;
          3'b010: alu_control = ALU_SLT;
          3'b100: alu_control = ALU_XOR;
          default: legal = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// RV32I multi-cycle control FSM over a shared instruction/data memory.
// Define RV_CTRL_TRAP_EN to trap illegal instructions (illegal_o).
module rv_multicycle_ctrl
  import rv_pkg::*;
#(
  parameter bit RESET_STATE_FETCH = 1'b1
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  output logic [3:0]  alu_control,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  imm_src,
  output logic        adr_src,
  output logic [1:0]  result_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
`ifdef RV_CTRL_TRAP_EN
  output logic        illegal_o,
`endif
  output logic        reg_we
);

`ifdef RV_CTRL_TRAP_EN
  localparam ctrl_state_t ILL_ST = S_TRAP;
`else
  localparam ctrl_state_t ILL_ST = S_FETCH;
`endif

  ctrl_state_t state;
  ctrl_state_t next_state;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7;
  alu_cls_t   cls;
  logic       opc_ok;
  logic [3:0] dec_ctl;
  logic       dec_legal;
  logic       taken;
  logic       unused_bits;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[30];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign taken = br_taken(f3, alu_zero, alu_neg,
                          alu_carry, alu_overflow);

  // Map the opcode to an ALU class and flag unknown opcodes.
  always_comb begin
    cls    = CLS_ADD;
    opc_ok = 1'b1;
    unique case (1'b1)
      (opc == OPC_OP):     cls = CLS_R;
      (opc == OPC_OPIMM):  cls = CLS_I;
      (opc == OPC_BRANCH): cls = CLS_BR;
      (opc == OPC_LW),
      (opc == OPC_SW),
      (opc == OPC_JAL):    cls = CLS_ADD;
      default:             opc_ok = 1'b0;
    endcase
  end

  rv_alu_decoder u_dec (
    .cls         (cls),
    .funct3      (f3),
    .funct7_5    (f7),
    .alu_control (dec_ctl),
    .legal       (dec_legal)
  );

  // State register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (RESET_STATE_FETCH) state <= S_FETCH;
      else                   state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and outputs; everything is held quiet while in reset.
  always_comb begin
    next_state  = state;
    alu_control = ALU_ADD;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    imm_src     = IMM_I;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    reg_we      = 1'b0;
`ifdef RV_CTRL_TRAP_EN
    illegal_o   = 1'b0;
`endif
    if (rst_n) begin
      unique case (state)
        S_IDLE: begin
          if (mem_ready) next_state = S_FETCH;
        end
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            result_src = RES_ALU;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = (opc == OPC_BRANCH) ? IMM_B : IMM_J;
          if (!(opc_ok && dec_legal)) begin
            next_state = ILL_ST;
          end else begin
            case (opc)
              OPC_LW,
              OPC_SW:     next_state = S_MEMADR;
              OPC_OP:     next_state = S_EXECR;
              OPC_OPIMM:  next_state = S_EXECI;
              OPC_BRANCH: next_state = S_BRANCH;
              default:    next_state = S_JAL;
            endcase
          end
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = (opc == OPC_SW) ? IMM_S : IMM_I;
          if (opc == OPC_LW) next_state = S_MEMREAD;
          else               next_state = S_MEMWRITE;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) next_state = S_MEMWB;
        end
        S_MEMWRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) next_state = S_FETCH;
        end
        S_MEMWB: begin
          reg_we     = 1'b1;
          result_src = RES_MEM;
          next_state = S_FETCH;
        end
        S_EXECR: begin
          alu_src_a   = SRCA_RS1;
          alu_src_b   = SRCB_RS2;
          alu_control = dec_ctl;
          next_state  = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a   = SRCA_RS1;
          alu_src_b   = SRCB_IMM;
          imm_src     = IMM_I;
          alu_control = dec_ctl;
          next_state  = S_ALUWB;
        end
        S_ALUWB: begin
          reg_we     = 1'b1;
          result_src = RES_ALUOUT;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a   = SRCA_RS1;
          alu_src_b   = SRCB_RS2;
          alu_control = ALU_SUB;
          result_src  = RES_ALUOUT;
          pc_we       = taken;
          next_state  = S_FETCH;
        end
        S_JAL: begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          pc_we      = 1'b1;
          reg_we     = 1'b1;
          next_state = S_FETCH;
        end
        S_TRAP: begin
`ifdef RV_CTRL_TRAP_EN
          illegal_o = 1'b1;
`endif
          next_state = S_TRAP;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule
